// File: rtl/fadd_align_kgp.sv
// rtl/fadd_align_kgp.sv - FADD front end: unpack, magnitude order, align with GRS, emit kgp codes
// Sideband (sign/exp/eff_sub/special) is delayed to line up with the downstream prefix-tree output.
module fadd_align_kgp #(
  parameter int SB_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  output logic [63:0] kgp,
  output logic        sb_valid,
  output logic        sb_sign,
  output logic [7:0]  sb_exp,
  output logic        sb_eff_sub,
  output logic [1:0]  sb_special
);

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  // Stage 0: unpack and order by magnitude
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b, eff_exp_a, eff_exp_b;
  logic [23:0] mant_a, mant_b;
  logic        a_ge_b, eff_sub_c;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, mag_eq;

  assign sign_a    = a[31];
  assign sign_b    = b[31] ^ sub;
  assign exp_a     = a[30:23];
  assign exp_b     = b[30:23];
  assign eff_exp_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign eff_exp_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
  assign mant_a    = {exp_a != 8'd0, a[22:0]};
  assign mant_b    = {exp_b != 8'd0, b[22:0]};
  assign a_ge_b    = a[30:0] >= b[30:0];
  assign eff_sub_c = sign_a ^ sign_b;
  assign nan_a     = (&exp_a) & (|a[22:0]);
  assign nan_b     = (&exp_b) & (|b[22:0]);
  assign inf_a     = (&exp_a) & ~(|a[22:0]);
  assign inf_b     = (&exp_b) & ~(|b[22:0]);
  assign zero_a    = ~(|a[30:0]);
  assign zero_b    = ~(|b[30:0]);
  assign mag_eq    = a[30:0] == b[30:0];

  logic [23:0] s1_mant_x_d, s1_mant_y_d;
  logic [7:0]  s1_d_d, s1_exp_d;
  logic        s1_sign_d;
  logic [1:0]  s1_special_d;

  always_comb begin
    s1_mant_x_d  = a_ge_b ? mant_a : mant_b;
    s1_mant_y_d  = a_ge_b ? mant_b : mant_a;
    s1_d_d       = a_ge_b ? (eff_exp_a - eff_exp_b) : (eff_exp_b - eff_exp_a);
    s1_exp_d     = a_ge_b ? exp_a : exp_b;
    s1_sign_d    = a_ge_b ? sign_a : sign_b;
    s1_special_d = SP_NORMAL;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub_c)) begin
      s1_special_d = SP_NAN;
    end else if (inf_a || inf_b) begin
      s1_special_d = SP_INF;
      s1_sign_d    = inf_a ? sign_a : sign_b;
    end else if ((mag_eq && eff_sub_c) || (zero_a && zero_b)) begin
      s1_special_d = SP_ZERO;
      s1_sign_d    = sign_a & sign_b & zero_a & zero_b;
    end
  end

  logic        s1_valid_q, s1_eff_sub_q, s1_sign_q;
  logic [23:0] s1_mant_x_q, s1_mant_y_q;
  logic [7:0]  s1_d_q, s1_exp_q;
  logic [1:0]  s1_special_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_mant_x_q  <= '0;
      s1_mant_y_q  <= '0;
      s1_d_q       <= '0;
      s1_exp_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_special_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mant_x_q  <= s1_mant_x_d;
        s1_mant_y_q  <= s1_mant_y_d;
        s1_d_q       <= s1_d_d;
        s1_exp_q     <= s1_exp_d;
        s1_sign_q    <= s1_sign_d;
        s1_eff_sub_q <= eff_sub_c;
        s1_special_q <= s1_special_d;
      end
    end
  end

  // Stage 1 -> 2: align Y with sticky, invert on subtract, encode kgp
  logic [26:0] ext_x, ext_y, y_al, y_op, lost_mask;
  logic [63:0] kgp_d;

  assign ext_x = {s1_mant_x_q, 3'b000};
  assign ext_y = {s1_mant_y_q, 3'b000};

  always_comb begin
    lost_mask = '0;
    if (s1_d_q >= 8'd27) begin
      y_al = {26'd0, |s1_mant_y_q};
    end else begin
      lost_mask = (27'd1 << s1_d_q[4:0]) - 27'd1;
      y_al      = (ext_y >> s1_d_q[4:0]) | {26'd0, |(ext_y & lost_mask)};
    end
    y_op = s1_eff_sub_q ? ~y_al : y_al;
    kgp_d        = '0;
    kgp_d[1:0]   = {s1_eff_sub_q, s1_eff_sub_q};
    for (int i = 0; i < 27; i++) begin
      kgp_d[2*i+2 +: 2] = {ext_x[i] & y_op[i], ext_x[i] | y_op[i]};
    end
    for (int p = 28; p < 32; p++) begin
      kgp_d[2*p +: 2] = {1'b0, s1_eff_sub_q};
    end
  end

  logic        out_valid_q;
  logic [63:0] kgp_q;
  logic [12:0] sb_d;
  logic [12:0] sb_q [0:SB_DELAY];

  assign sb_d = {s1_valid_q,
                 s1_valid_q ? {s1_sign_q, s1_exp_q, s1_eff_sub_q, s1_special_q} : sb_q[0][11:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      kgp_q       <= '0;
      for (int k = 0; k <= SB_DELAY; k++) sb_q[k] <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) kgp_q <= kgp_d;
      sb_q[0] <= sb_d;
      for (int k = 1; k <= SB_DELAY; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  assign out_valid  = out_valid_q;
  assign kgp        = kgp_q;
  assign sb_valid   = sb_q[SB_DELAY][12];
  assign sb_sign    = sb_q[SB_DELAY][11];
  assign sb_exp     = sb_q[SB_DELAY][10:3];
  assign sb_eff_sub = sb_q[SB_DELAY][2];
  assign sb_special = sb_q[SB_DELAY][1:0];

endmodule

// File: tb/tb_fadd_align_kgp.sv
// tb/tb_fadd_align_kgp.sv - randomized and directed bench for fadd_align_kgp against a behavioural model
module tb_fadd_align_kgp;
  localparam int SBD  = 4;
  localparam int MAXC = 2000;

  logic        clk = 1'b0;
  logic        reset, in_valid, sub;
  logic [31:0] a, b;
  logic        out_valid, sb_valid, sb_sign, sb_eff_sub;
  logic [63:0] kgp;
  logic [7:0]  sb_exp;
  logic [1:0]  sb_special;

  always #5 clk = ~clk;

  fadd_align_kgp #(.SB_DELAY(SBD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .kgp(kgp), .sb_valid(sb_valid), .sb_sign(sb_sign),
    .sb_exp(sb_exp), .sb_eff_sub(sb_eff_sub), .sb_special(sb_special)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        acc    [MAXC];
  logic        rst_at [MAXC];
  logic [63:0] e_kgp  [MAXC];
  logic        e_sign [MAXC];
  logic [7:0]  e_exp  [MAXC];
  logic        e_eff  [MAXC];
  logic [1:0]  e_spec [MAXC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: plain arithmetic on the IEEE fields
  function automatic void model(input logic [31:0] fa, input logic [31:0] fb, input logic s,
                                output logic [63:0] k, output logic sg, output logic [7:0] ex,
                                output logic ef, output logic [1:0] sp);
    logic   sa, sbb, a_big, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    int     ea, eb, effa, effb, d;
    longint ma, mb, mx, my, xm, ym, yv, xs, ys, xb, yb, div;
    sa    = fa[31];
    sbb   = fb[31] ^ s;
    ea    = int'(fa[30:23]);
    eb    = int'(fb[30:23]);
    ma    = longint'(fa[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
    mb    = longint'(fb[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
    effa  = (ea == 0) ? 1 : ea;
    effb  = (eb == 0) ? 1 : eb;
    a_big = fa[30:0] >= fb[30:0];
    mx    = a_big ? ma : mb;
    my    = a_big ? mb : ma;
    d     = a_big ? effa - effb : effb - effa;
    sg    = a_big ? sa : sbb;
    ex    = a_big ? fa[30:23] : fb[30:23];
    ef    = sa ^ sbb;
    xm    = mx * 8;
    if (d >= 27) begin
      ym = (my != 0) ? 1 : 0;
    end else begin
      div = longint'(1) << d;
      ym  = (my * 8) / div;
      if (((my * 8) % div) != 0) ym = ym | 1;
    end
    yv = ef ? (134217727 - ym) : ym;
    xs = xm * 2 + (ef ? 1 : 0);
    ys = yv * 2 + (ef ? 1 : 0) + (ef ? (longint'(15) << 28) : 0);
    for (int p = 0; p < 32; p++) begin
      xb = (xs >> p) & 1;
      yb = (ys >> p) & 1;
      k[2*p +: 2] = (xb == 1 && yb == 1) ? 2'b11 : ((xb == 1 || yb == 1) ? 2'b01 : 2'b00);
    end
    nan_a = (ea == 255) && (fa[22:0] != 0);
    nan_b = (eb == 255) && (fb[22:0] != 0);
    inf_a = (ea == 255) && (fa[22:0] == 0);
    inf_b = (eb == 255) && (fb[22:0] == 0);
    z_a   = fa[30:0] == 0;
    z_b   = fb[30:0] == 0;
    sp    = 2'b00;
    if (nan_a || nan_b || (inf_a && inf_b && ef)) begin
      sp = 2'b11;
    end else if (inf_a || inf_b) begin
      sp = 2'b10;
      sg = inf_a ? sa : sbb;
    end else if ((fa[30:0] == fb[30:0] && ef) || (z_a && z_b)) begin
      sp = 2'b01;
      sg = sa && sbb && z_a && z_b;
    end
  endfunction

  task automatic verify(input int n);
    if (rst_at[n]) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_kgp", kgp, 64'd0);
      check("rst_sideband", 64'({sb_valid, sb_sign, sb_exp, sb_eff_sub, sb_special}), 64'd0);
    end else begin
      if (n >= 1) begin
        check("out_valid", 64'(out_valid), 64'(acc[n-1]));
        if (acc[n-1]) check("kgp", kgp, e_kgp[n-1]);
      end
      if (n >= 1 + SBD) begin
        check("sb_valid", 64'(sb_valid), 64'(acc[n-1-SBD]));
        if (acc[n-1-SBD]) begin
          check("sb_sign", 64'(sb_sign), 64'(e_sign[n-1-SBD]));
          check("sb_exp", 64'(sb_exp), 64'(e_exp[n-1-SBD]));
          check("sb_eff_sub", 64'(sb_eff_sub), 64'(e_eff[n-1-SBD]));
          check("sb_special", 64'(sb_special), 64'(e_spec[n-1-SBD]));
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                      input logic s, input logic r);
    @(negedge clk);
    in_valid = v; a = av; b = bv; sub = s; reset = r;
    @(posedge clk);
    #1;
    rst_at[cyc] = r;
    acc[cyc]    = v & ~r;
    e_kgp[cyc] = '0; e_sign[cyc] = 1'b0; e_exp[cyc] = '0; e_eff[cyc] = 1'b0; e_spec[cyc] = '0;
    if (acc[cyc]) model(av, bv, s, e_kgp[cyc], e_sign[cyc], e_exp[cyc], e_eff[cyc], e_spec[cyc]);
    if (r) for (int j = 0; j < cyc; j++) acc[j] = 1'b0;
    verify(cyc);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:0] = '0;
      1: r[30:0] = {8'hFF, 23'd0};
      2: begin r[30:23] = 8'hFF; if (r[22:0] == 23'd0) r[0] = 1'b1; end
      3: r[30:23] = 8'h00;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] x);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[30:0] = x[30:0];
      1: r[30:23] = (x[30:23] > 8'd30) ? x[30:23] - 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 30));
      default: r = rand_fp();
    endcase
    return r;
  endfunction

  logic [31:0] ra, rb;

  initial begin
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);

    // 1.0 + 1.0
    step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    idle(1);
    check("tp_add_kgp", kgp, 64'h00C0000000000000);
    idle(SBD);
    check("tp_add_sb", 64'({sb_valid, sb_sign, sb_exp, sb_eff_sub, sb_special}),
          64'({1'b1, 1'b0, 8'h7F, 1'b0, 2'b00}));

    // 1.0 - 1.0
    step(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    idle(1);
    check("tp_sub_pos0", 64'(kgp[1:0]), 64'd3);
    check("tp_sub_pos28_31", 64'(kgp[63:56]), 64'h55);
    idle(SBD);
    check("tp_sub_sb", 64'({sb_sign, sb_eff_sub, sb_special}), 64'({1'b0, 1'b1, 2'b01}));

    // 1.0 + 2^-30: shift saturates to sticky only
    step(1'b1, 32'h3F800000, 32'h30800000, 1'b0, 1'b0);
    idle(1);
    check("tp_sat_kgp", kgp, 64'h0040000000000004);
    idle(SBD);

    // +inf + -inf, then +inf + 1.0
    step(1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 32'h3F800000, 1'b0, 1'b0);
    idle(SBD);
    check("tp_infinf_spec", 64'(sb_special), 64'd3);
    idle(1);
    check("tp_inf1_spec", 64'({sb_sign, sb_special}), 64'({1'b0, 2'b10}));

    // 1.0 + -4.0: operands swap, B wins
    step(1'b1, 32'h3F800000, 32'hC0800000, 1'b0, 1'b0);
    idle(1);
    check("tp_swap_kgp", kgp, 64'h55D1555555555557);
    idle(SBD);
    check("tp_swap_sb", 64'({sb_sign, sb_exp, sb_eff_sub, sb_special}),
          64'({1'b1, 8'h81, 1'b1, 2'b00}));

    // Back-to-back stream with reset on op 4
    for (int i = 1; i <= 8; i++) begin
      ra = rand_fp();
      rb = rand_partner(ra);
      step(1'b1, ra, rb, 1'($urandom_range(0, 1)), (i == 4) ? 1'b1 : 1'b0);
    end
    idle(SBD + 2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      ra = rand_fp();
      rb = rand_partner(ra);
      if ($urandom_range(0, 1) == 1) begin
        ra = rb; rb = rand_partner(ra);
      end
      step(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0));
    end
    idle(SBD + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fadd_align_kgp.md
Name: fadd_align_kgp

Overview:
Front-end stage of the FADD pipeline. It sits directly upstream of the prefix-tree compute block and feeds it. It unpacks two IEEE-754 single-precision operands, orders them by magnitude, aligns the smaller mantissa with guard/round/sticky bits, and emits the 64-bit kgp vector (32 positions x 2 bits) that the prefix levels consume. Result sign, exponent and special-case flags travel on a delay line so they arrive in step with the compute output.

Parameters:
SB_DELAY, 4, extra register stages on the sideband after the 2-cycle align path. Matches the compute block's register depth.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands valid this cycle
a  input  32  IEEE-754 single operand A
b  input  32  IEEE-754 single operand B
sub  input  1  1 = compute A-B, 0 = A+B
out_valid  output  1  kgp valid; goes to compute input
kgp  output  64  per-position code, position i at bits [2i+1:2i]
sb_valid  output  1  sideband valid, aligned to compute output
sb_sign  output  1  result sign
sb_exp  output  8  biased exponent of the larger operand
sb_eff_sub  output  1  effective subtraction
sb_special  output  2  00 normal, 01 exact zero, 10 infinity, 11 NaN

Behaviour:
- kgp encoding: kill = 00 (x=y=0), propagate = 01 (x!=y), generate = 11 (x=y=1). Code 10 is never emitted.
- Unpack:
  - hidden bit = (exp != 0).
  - Effective exponent = 1 when exp == 0 (denormal).
  - B sign is inverted when sub = 1.
  - eff_sub = sign(A) XOR sign(B after inversion).
- Stage 1 (registered, cycle 1):
  - Compare {exp, frac} of A and B (31 bits, unsigned).
  - X = larger; ties pick A.
  - d = effX - effY.
  - Register X/Y mantissas, d, signs, eff_sub, special flags.
- Stage 2 (registered, cycle 2):
  - 27-bit operands: {hidden, frac, G, R, S}.
  - Xm = mantX << 3.
  - Ym = (mantY << 3) >> d. S = OR of all bits shifted out.
  - If d >= 27: Ym = {26'b0, (mantY != 0)}.
  - If eff_sub = 1: y operand = ~Ym, cin = 1; otherwise y = Ym, cin = 0.
- Position map:
  - Position 0 = carry-in: g if cin, else k.
  - Positions 1..27 = Xm/y bits 0..26.
  - Positions 28..31: x = 0, y = eff_sub. This gives p on subtract and k on add.
- Latency and throughput:
  - out_valid and kgp appear 2 cycles after in_valid; throughput 1 per cycle; no back-pressure.
  - Sideband appears 2 + SB_DELAY cycles after in_valid.
  - sb_* is a pure shift of the stage-2 values; sb_valid shifts with it.
- Sign and exponent:
  - sb_sign = sign of X.
  - sb_exp = exp of X; if X is denormal, sb_exp = 0x00.
- Specials, priority NaN > inf > zero:
  - NaN if either operand is NaN, or inf with inf and eff_sub.
  - Inf if either operand is inf (sign of that operand).
  - Exact zero if magnitudes are equal and eff_sub, or both operands are zero.
  - Exact-zero sign = 0, except -0 + -0 (after sub inversion) gives 1.
  - kgp is still generated normally for specials; downstream obeys sb_special.
- Invalid cycles: out_valid = 0; kgp/sb data hold their last value (don't-care).
- Reset:
  - Synchronous. On the edge where reset = 1, all valids, kgp and sideband registers clear to 0.
  - In-flight operations are dropped, with no partial output.
  - in_valid during reset is ignored.
  - The first operand accepted in the cycle after reset deasserts appears 2 cycles later.

Test Plan:
- 1.0+1.0 (a=b=0x3F800000, sub=0) -> after 2 cycles out_valid=1, kgp=64'h00C0000000000000. After 6 cycles sb_valid=1, sb_exp=0x7F, sb_sign=0, sb_special=00, sb_eff_sub=0.
- 1.0-1.0 (sub=1) -> sb_special=01, sb_sign=0, sb_eff_sub=1. kgp position 0 = 11, positions 28..31 = 01.
- 1.0 + 2^-30 (a=0x3F800000, b=0x30800000) -> d=30 saturates. kgp=64'h0040000000000004 (position 27 p, sticky position 1 p).
- +inf + -inf (0x7F800000, 0xFF800000, sub=0) -> sb_special=11. +inf + 1.0 -> sb_special=10, sb_sign=0.
- Swap/sign: a=1.0, b=-4.0 (0xC0800000), sub=0 -> X=B, sb_sign=1, sb_exp=0x81, eff_sub=1, Ym = 0x4000000 >> 2.
- Stream 8 back-to-back valid ops, assert reset for 1 cycle at op 4 -> outputs for ops 1..3 only if already past stage 2, then out_valid=0 and sb_valid=0 next cycle. Post-reset op emerges exactly 2 cycles (kgp) and 6 cycles (sideband) after issue.
